fp32_accum_seq: RTL
===================

Name: fp32_accum_seq

Overview:
- Sequential FP32 reduction stage that sits directly upstream of the combinational Addsub_32 adder and consumes its result.
- Accepts a valid/ready stream of FP32 operands grouped into packets by in_last.
- Drives each operand and the running accumulator into Addsub_32, registers the sum, and emits one FP32 result per packet.
- Used by the non-linear approximation engine for series and polynomial sums.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported (IEEE-754 single).
CNT_W, 8, width of the per-packet beat counter.

Ports:
clk_n  input  1  clock; all state updates on its rising edge.
rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat.
in_data  input  WIDTH  FP32 operand.
in_sub  input  1  1 = subtract this operand (acc - in_data); 0 = add.
in_last  input  1  final beat of packet.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_data  output  WIDTH  FP32 packet sum.
out_count  output  CNT_W  beats accumulated in packet (saturating).
out_sat  output  1  beat count exceeded 2^CNT_W-1.
busy  output  1  packet in progress or result pending.

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, count=0, sat=0. out_valid=0, out_data=0, out_count=0, out_sat=0, busy=0, in_ready=1.
- Beat accepted when in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1, busy=0. On accept, acc <= {in_data[31]^in_sub, in_data[30:0]}; no adder involvement. count <= 1. Next state is HOLD if in_last, else ACCUM.
  - ACCUM: in_ready=1, busy=1. On accept, acc <= Addsub_32(mode=in_sub, A=acc, B=in_data). count <= count+1, saturating at all-ones; set sat when an increment is attempted at all-ones. Next state is HOLD if in_last. With no accept, hold all state.
  - HOLD: in_ready=0, busy=1, out_valid=1. out_data=acc, out_count=count, out_sat=sat, all stable until handshake. On out_ready, next state IDLE; count and sat clear, acc keeps its value.
- Throughput: one beat per cycle in ACCUM.
- Latency: out_valid asserts the cycle after the in_last beat is accepted.
- Minimum packet period is N+1 cycles for N beats, because in_ready is low in HOLD and there is no pass-through of out_ready into in_ready.
- Single-beat packet (IDLE with in_last): result is the sign-adjusted operand, count=1.
- in_sub and in_last are sampled only on accepted beats. in_data may change freely when not accepted.
- The adder is purely combinational: one Addsub_32 feeds the acc D-input through a mux (load vs sum). No extra pipeline register.
- Reset mid-packet or mid-HOLD: the partial sum is discarded and the result is never emitted.
- Zero, denormal, Inf and NaN handling is whatever Addsub_32 produces; this block adds no special-casing.

Decomposition:
- Shared package nla_fp_pkg holds:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23.
  - FSM state encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Common FP32 constants: FP_ZERO=32'h0, FP_ONE=32'h3F800000.
- Single sub-module: Addsub_32, instantiated once with WIDTH passed through.
- Everything else (FSM, counter, accumulator register) is flat in fp32_accum_seq.

Test Plan:
- Add packet: 3F800000, 40000000, 40400000 (last), in_sub=0, out_ready=1 -> out_valid 1 cycle after the last beat; out_data=40C00000 (6.0), out_count=3, out_sat=0.
- Subtract: 40800000 (in_sub=0), then 3FC00000 (in_sub=1, last) -> out_data=40200000 (2.5), out_count=2. Also a single beat 3F800000 with in_sub=1, last -> out_data=BF800000.
- Backpressure: hold out_ready=0 for 5 cycles after the last beat, with in_valid held high on new data -> in_ready=0, out_data, out_count and out_valid stable throughout. Raising out_ready completes the handshake, and the next cycle in_ready=1 in IDLE.
- Stalled input: in_valid toggles 1,0,0,1,1(last) over 3F000000 x3 -> out_data=3FC00000 (1.5), out_count=3, and acc unchanged on idle cycles.
- Saturation, CNT_W=2: 5 beats of 3F800000 -> out_data=40A00000 (5.0), out_count=3, out_sat=1. The next packet of one beat reports count=1, out_sat=0.
- Reset mid-packet: assert rst_n after 2 of 4 beats, asynchronously between edges -> out_valid, out_data and busy drop to 0 immediately. A new packet 40000000 (last) then yields 40000000, count=1.

Source files
------------

// File: rtl/nla_fp_pkg.sv
// Shared FP32 field layout, reduction FSM encoding and common constants for the
// non-linear approximation engine.
package nla_fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Flip the sign of an FP32 word when neg is set; magnitude bits pass untouched.
    function automatic logic [31:0] fp_neg_if(input logic [31:0] x, input logic neg);
        return {x[SIGN_BIT] ^ neg, x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fp32_accum_seq_addsub.sv
// Combinational IEEE-754 single-precision add/subtract (round to nearest even,
// gradual underflow, Inf/NaN propagation). i_mode=1 computes i_a - i_b.
module Addsub_32
    import nla_fp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    localparam int EXP_W = EXP_MSB - EXP_LSB + 1;
    localparam int EXT_W = MAN_W + 4;

    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_swap, w_eff_sub;
    logic             w_big_s, w_sml_s;
    logic [EXP_W:0]   w_big_e, w_sml_e, w_diff, w_lim;
    logic [EXT_W-1:0] w_big_m, w_sml_m, w_sml_al, w_mask, w_norm;
    logic [EXT_W:0]   w_raw;
    logic [4:0]       w_lz, w_shl;
    logic [EXP_W+1:0] w_exp, w_exp_f;
    logic             w_rnd_up;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W:0]   w_mant;

    assign w_sa = i_a[SIGN_BIT];
    assign w_sb = i_b[SIGN_BIT] ^ i_mode;
    assign w_ea = i_a[EXP_MSB:EXP_LSB];
    assign w_eb = i_b[EXP_MSB:EXP_LSB];
    assign w_ma = i_a[MAN_W-1:0];
    assign w_mb = i_b[MAN_W-1:0];

    assign w_a_nan = (&w_ea) && (|w_ma);
    assign w_b_nan = (&w_eb) && (|w_mb);
    assign w_a_inf = (&w_ea) && !(|w_ma);
    assign w_b_inf = (&w_eb) && !(|w_mb);

    always_comb begin
        w_swap   = (i_b[SIGN_BIT-1:0] > i_a[SIGN_BIT-1:0]);
        w_big_s  = w_swap ? w_sb : w_sa;
        w_sml_s  = w_swap ? w_sa : w_sb;
        w_big_e  = {1'b0, (w_swap ? w_eb : w_ea)};
        w_sml_e  = {1'b0, (w_swap ? w_ea : w_eb)};
        // Denormals share the exponent of the smallest normal, without the hidden one.
        w_big_m  = w_swap ? {(|w_eb), w_mb, 3'b000} : {(|w_ea), w_ma, 3'b000};
        w_sml_m  = w_swap ? {(|w_ea), w_ma, 3'b000} : {(|w_eb), w_mb, 3'b000};
        if (w_big_e == '0) w_big_e = (EXP_W+1)'(1);
        if (w_sml_e == '0) w_sml_e = (EXP_W+1)'(1);
        w_diff    = w_big_e - w_sml_e;
        w_eff_sub = w_big_s ^ w_sml_s;

        // Align the smaller operand; everything shifted out collapses into the sticky bit.
        w_mask   = ~({EXT_W{1'b1}} << w_diff);
        w_sml_al = '0;
        if (w_diff >= (EXP_W+1)'(EXT_W)) begin
            w_sml_al[0] = |w_sml_m;
        end else begin
            w_sml_al    = w_sml_m >> w_diff;
            w_sml_al[0] = w_sml_al[0] | (|(w_sml_m & w_mask));
        end

        w_raw = w_eff_sub ? ({1'b0, w_big_m} - {1'b0, w_sml_al})
                          : ({1'b0, w_big_m} + {1'b0, w_sml_al});

        w_lz = 5'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (w_raw[i]) w_lz = 5'(EXT_W - 1 - i);
        end
        // Never normalise below the minimum exponent: the result stays denormal instead.
        w_lim = w_big_e - (EXP_W+1)'(1);
        w_shl = (w_lim < {4'b0, w_lz}) ? w_lim[4:0] : w_lz;

        if (w_raw[EXT_W]) begin
            w_norm = {w_raw[EXT_W:2], w_raw[1] | w_raw[0]};
            w_exp  = {1'b0, w_big_e} + (EXP_W+2)'(1);
        end else begin
            w_norm = w_raw[EXT_W-1:0] << w_shl;
            w_exp  = {1'b0, w_big_e} - {5'b0, w_shl};
        end

        w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd    = {1'b0, w_norm[EXT_W-1:3]} + {{(MAN_W+1){1'b0}}, w_rnd_up};
        if (w_rnd[MAN_W+1]) begin
            w_exp_f = w_exp + (EXP_W+2)'(1);
            w_mant  = w_rnd[MAN_W+1:1];
        end else begin
            w_exp_f = w_exp;
            w_mant  = w_rnd[MAN_W:0];
        end

        if (w_exp_f >= (EXP_W+2)'(255))
            o_sum = {w_big_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            o_sum = {w_big_s, (w_mant[MAN_W] ? w_exp_f[EXP_W-1:0] : {EXP_W{1'b0}}),
                     w_mant[MAN_W-1:0]};

        // Exact cancellation yields +0; only (-0) + (-0) keeps the negative sign.
        if (w_raw == '0)
            o_sum = {w_big_s & w_sml_s, {(WIDTH-1){1'b0}}};

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            o_sum = FP_QNAN;
        else if (w_a_inf)
            o_sum = i_a;
        else if (w_b_inf)
            o_sum = {w_sb, i_b[SIGN_BIT-1:0]};
    end

endmodule

// File: rtl/fp32_accum_seq.sv
// Sequential FP32 packet reducer: folds a valid/ready operand stream into one
// sum per packet through a single combinational Addsub_32.
module fp32_accum_seq
    import nla_fp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             busy
);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [WIDTH-1:0] w_sum, w_load, w_acc_d;
    logic             w_accept;

    Addsub_32 #(.WIDTH(WIDTH)) u_addsub (
        .i_mode (in_sub),
        .i_a    (r_acc),
        .i_b    (in_data),
        .o_sum  (w_sum)
    );

    assign w_accept = in_valid && in_ready;
    assign w_load   = fp_neg_if(in_data, in_sub);
    // First beat of a packet loads directly; later beats take the adder output.
    assign w_acc_d  = (r_state == IDLE) ? w_load : w_sum;

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && in_last) w_next = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign out_data  = out_valid ? r_acc   : FP_ZERO;
    assign out_count = out_valid ? r_count : '0;
    assign out_sat   = out_valid && r_sat;

    always_ff @(posedge clk_n or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_acc   <= FP_ZERO;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc <= w_acc_d;
                if (r_state == IDLE) begin
                    r_count <= CNT_W'(1);
                    r_sat   <= 1'b0;
                end else if (&r_count) begin
                    r_sat   <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if ((r_state == HOLD) && out_ready) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end
        end
    end

endmodule
